// File: rtl/layer_sequencer.sv
// Layer scheduler for the inference datapath: walks EMB -> MIX1..3 -> DENS for a
// programmable number of passes, with abort, watchdog timeout and start/done pulses.

package layer_seq_pkg;
  localparam int STATE_LEN = 3;
  localparam int MODE_LEN  = 2;

  typedef enum logic [STATE_LEN-1:0] {
    IDLE = 3'd0,
    EMB  = 3'd1,
    MIX1 = 3'd2,
    MIX2 = 3'd3,
    MIX3 = 3'd4,
    DENS = 3'd5
  } state_t;

  localparam logic [MODE_LEN-1:0] GEN_PLAIN = 2'd0;
  localparam logic [MODE_LEN-1:0] GEN_SIMI  = 2'd1;
  localparam logic [MODE_LEN-1:0] GEN_ALT   = 2'd2;
  localparam logic [MODE_LEN-1:0] GEN_FULL  = 2'd3;
endpackage

module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 abort,
  input  logic [MODE_LEN-1:0]  mode,
  input  logic [3:0]           n_iter,
  input  logic                 valid_emb,
  input  logic                 valid_mix,
  input  logic                 valid_dens,
  output logic [STATE_LEN-1:0] state,
  output logic [MODE_LEN-1:0]  mode_q,
  output logic [3:0]           iter,
  output logic                 layer_start,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t              state_reg, state_next;
  logic [MODE_LEN-1:0] mode_reg, mode_next;
  logic [3:0]          n_iter_reg, n_iter_next;
  logic [3:0]          iter_reg, iter_next;
  logic [CNT_W-1:0]    wd_cnt_reg, wd_cnt_next;
  logic                layer_start_reg, layer_start_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic layer_valid;
  logic wd_expired;
  logic last_iter;

  // Only the valid belonging to the layer that currently owns the datapath counts.
  always_comb begin
    layer_valid = 1'b0;
    case (state_reg)
      EMB:              layer_valid = valid_emb;
      MIX1, MIX2, MIX3: layer_valid = valid_mix;
      DENS:             layer_valid = valid_dens;
      default:          layer_valid = 1'b0;
    endcase
  end

  assign wd_expired = (wd_cnt_reg == CNT_W'(TIMEOUT));
  assign last_iter  = (iter_reg == n_iter_reg - 4'd1);

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    n_iter_next = n_iter_reg;
    iter_next   = iter_reg;
    err_next    = err_reg;
    done_next   = 1'b0;

    if (state_reg == IDLE) begin
      // abort alongside run keeps the sequencer parked
      if (run && !abort) begin
        state_next  = EMB;
        mode_next   = mode;
        n_iter_next = (n_iter == 4'd0) ? 4'd1 : n_iter;
        iter_next   = 4'd0;
        err_next    = 1'b0;
      end
    end else if (abort) begin
      state_next = IDLE;
    end else if (layer_valid) begin
      case (state_reg)
        EMB:  state_next = MIX1;
        MIX1: state_next = MIX2;
        MIX2: state_next = MIX3;
        MIX3: state_next = DENS;
        DENS: begin
          if (last_iter) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            iter_next  = iter_reg + 4'd1;
            state_next = EMB;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (wd_expired) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end

    // Counter restarts on every layer change so each layer gets the full budget.
    if (state_next != state_reg || state_reg == IDLE) begin
      wd_cnt_next = '0;
    end else begin
      wd_cnt_next = wd_cnt_reg + 1'b1;
    end

    layer_start_next = (state_next != IDLE) && (state_next != state_reg);
    busy_next        = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      mode_reg        <= '0;
      n_iter_reg      <= 4'd1;
      iter_reg        <= 4'd0;
      wd_cnt_reg      <= '0;
      layer_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mode_reg        <= mode_next;
      n_iter_reg      <= n_iter_next;
      iter_reg        <= iter_next;
      wd_cnt_reg      <= wd_cnt_next;
      layer_start_reg <= layer_start_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
    end
  end

  assign state       = state_reg;
  assign mode_q      = mode_reg;
  assign iter        = iter_reg;
  assign layer_start = layer_start_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a cycle-level behavioural model is checked
// against the DUT every cycle, plus hand-computed expectations per scenario.

module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 run = 1'b0;
  logic                 abort = 1'b0;
  logic [MODE_LEN-1:0]  mode = '0;
  logic [3:0]           n_iter = '0;
  logic                 valid_emb = 1'b0;
  logic                 valid_mix = 1'b0;
  logic                 valid_dens = 1'b0;
  logic [STATE_LEN-1:0] state;
  logic [MODE_LEN-1:0]  mode_q;
  logic [3:0]           iter;
  logic                 layer_start, busy, done, err;

  int compared   = 0;
  int mismatched = 0;
  int ls_cnt     = 0;
  int done_cnt   = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .mode(mode), .n_iter(n_iter),
    .valid_emb(valid_emb), .valid_mix(valid_mix), .valid_dens(valid_dens),
    .state(state), .mode_q(mode_q), .iter(iter), .layer_start(layer_start),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;
  int e_entry = 0;
  int e_state = 0, e_mode = 0, e_nq = 1, e_iter = 0;
  int e_ls = 0, e_done = 0, e_err = 0;

  function automatic bit owner_done(input int s);
    return (s == 1 && valid_emb) || (s >= 2 && s <= 4 && valid_mix) || (s == 5 && valid_dens);
  endfunction

  always @(posedge clk) begin : model
    int nxt;
    cyc++;
    e_ls = 0;
    e_done = 0;
    if (rst) begin
      e_state = 0; e_mode = 0; e_nq = 1; e_iter = 0; e_err = 0; e_entry = cyc;
    end else begin
      nxt = e_state;
      if (e_state == 0) begin
        if (run && !abort) begin
          nxt = 1;
          e_mode = int'(mode);
          e_nq = (n_iter == 0) ? 1 : int'(n_iter);
          e_iter = 0;
          e_err = 0;
        end
      end else if (abort) begin
        nxt = 0;
      end else if (owner_done(e_state)) begin
        if (e_state == 5) begin
          if (e_iter == e_nq - 1) begin
            nxt = 0;
            e_done = 1;
          end else begin
            e_iter++;
            nxt = 1;
          end
        end else begin
          nxt = e_state + 1;
        end
      end else if (cyc - 1 - e_entry == TO) begin
        // the cycle ending here is cycle TO since this layer was entered
        nxt = 0;
        e_err = 1;
      end
      if (nxt != e_state) begin
        e_entry = cyc;
        e_ls = (nxt != 0) ? 1 : 0;
      end
      e_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("m_state", int'(state), e_state);
      check("m_busy", int'(busy), (e_state != 0) ? 1 : 0);
      check("m_iter", int'(iter), e_iter);
      check("m_mode_q", int'(mode_q), e_mode);
      check("m_layer_start", int'(layer_start), e_ls);
      check("m_done", int'(done), e_done);
      check("m_err", int'(err), e_err);
      if (layer_start === 1'b1) ls_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        $display("run done: mode_q=%0d iter=%0d t=%0t", mode_q, iter, $time);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_run(input int m, input int n);
    @(negedge clk);
    run = 1'b1;
    mode = m[MODE_LEN-1:0];
    n_iter = n[3:0];
    @(negedge clk);
    run = 1'b0;
    $display("run started: mode=%0d n_iter=%0d t=%0t", m, n, $time);
  endtask

  // which: 0 = emb, 1 = mix, 2 = dens; returns on the negedge the new layer is visible
  task automatic pulse(input int which, input int gap);
    repeat (gap) @(negedge clk);
    case (which)
      0: valid_emb = 1'b1;
      1: valid_mix = 1'b1;
      default: valid_dens = 1'b1;
    endcase
    @(negedge clk);
    valid_emb = 1'b0;
    valid_mix = 1'b0;
    valid_dens = 1'b0;
  endtask

  task automatic one_pass(input int gap);
    pulse(0, gap);
    pulse(1, gap);
    pulse(1, gap);
    pulse(1, gap);
    pulse(2, gap);
  endtask

  int ls0, d0, n;
  int pat[6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_iter", int'(iter), 0);
    rst = 1'b0;

    // 1: single pass, 3-cycle gaps
    ls0 = ls_cnt; d0 = done_cnt;
    start_run(int'(GEN_SIMI), 1);
    check("t1_emb", int'(state), 1);
    one_pass(3);
    #1;
    check("t1_idle", int'(state), 0);
    check("t1_done", int'(done), 1);
    check("t1_ls_count", ls_cnt - ls0, 5);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_mode_q", int'(mode_q), int'(GEN_SIMI));
    check("t1_err", int'(err), 0);
    @(negedge clk); #1;
    check("t1_done_low", int'(done), 0);

    // 2: three passes, then n_iter=0
    ls0 = ls_cnt; d0 = done_cnt;
    start_run(2, 3);
    for (int p = 0; p < 3; p++) begin
      check("t2_iter", int'(iter), p);
      one_pass(0);
    end
    #1;
    check("t2_ls_count", ls_cnt - ls0, 15);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_idle", int'(state), 0);
    d0 = done_cnt;
    start_run(2, 0);
    one_pass(0);
    #1;
    check("t2_n0_done", done_cnt - d0, 1);
    check("t2_n0_iter", int'(iter), 0);

    // 3: wrong-layer valids and run while busy
    start_run(0, 1);
    valid_mix = 1'b1; valid_dens = 1'b1;
    repeat (4) @(negedge clk);
    valid_mix = 1'b0; valid_dens = 1'b0;
    check("t3_hold_emb", int'(state), 1);
    pulse(0, 0);
    check("t3_mix1", int'(state), 2);
    pulse(1, 1);
    check("t3_mix2", int'(state), 3);
    run = 1'b1; mode = 2'd3; n_iter = 4'd7;
    @(negedge clk);
    run = 1'b0;
    check("t3_mode_q_kept", int'(mode_q), 0);
    d0 = done_cnt;
    pulse(1, 0);
    pulse(1, 0);
    pulse(2, 0);
    #1;
    check("t3_single_pass", int'(state), 0);
    check("t3_done", done_cnt - d0, 1);

    // 4: watchdog in MIX2
    d0 = done_cnt;
    start_run(1, 1);
    pulse(0, 0);
    pulse(1, 0);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (state == 3'd0) begin
        n = k;
        break;
      end
    end
    check("t4_wd_cycles", n, 17);
    #1;
    check("t4_err", int'(err), 1);
    check("t4_no_done", done_cnt - d0, 0);
    start_run(1, 1);
    check("t4_err_cleared", int'(err), 0);
    pulse(0, 0);
    pulse(1, 0);
    repeat (TO) @(negedge clk);
    valid_mix = 1'b1;
    @(negedge clk);
    valid_mix = 1'b0;
    check("t4_valid_wins", int'(state), 4);
    check("t4_valid_err", int'(err), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_idle", int'(state), 0);

    // 5: abort, abort+run, reset mid-run
    d0 = done_cnt;
    start_run(2, 1);
    pulse(0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("t5_abort_idle", int'(state), 0);
    check("t5_abort_done", done_cnt - d0, 0);
    check("t5_abort_err", int'(err), 0);
    @(negedge clk);
    abort = 1'b1; run = 1'b1;
    @(negedge clk);
    abort = 1'b0; run = 1'b0;
    check("t5_abort_run", int'(state), 0);
    start_run(3, 2);
    pulse(0, 0);
    pulse(1, 0);
    pulse(1, 0);
    pulse(1, 0);
    check("t5_in_dens", int'(state), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_state", int'(state), 0);
    check("t5_rst_mode_q", int'(mode_q), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_ls", int'(layer_start), 0);
    check("t5_rst_done", int'(done), 0);

    // 6: back-to-back runs with run and all valids held high
    @(negedge clk);
    run = 1'b1; mode = 2'd1; n_iter = 4'd1;
    valid_emb = 1'b1; valid_mix = 1'b1; valid_dens = 1'b1;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (state == 3'd1) begin
        n = k;
        break;
      end
    end
    check("t6_started", (n > 0) ? 1 : 0, 1);
    for (int i = 0; i < 18; i++) begin
      check("t6_pattern", int'(state), pat[i % 6]);
      @(negedge clk);
    end
    run = 1'b0;
    valid_emb = 1'b0; valid_mix = 1'b0; valid_dens = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
